// File: rtl/vram_pkg.sv
// Shared definitions for the host-side VRAM write path: default address
// width, host register select codes, status/control bit positions and the
// VRAM port slot arbitration rule.
package vram_pkg;

  localparam int unsigned VRAM_ADDR_W = 13;
  localparam int unsigned DATA_W      = 8;

  // Host register select codes
  typedef enum logic [1:0] {
    RS_ADDR_LO = 2'd0,
    RS_ADDR_HI = 2'd1,
    RS_DATA    = 2'd2,
    RS_CTRL    = 2'd3
  } host_rs_e;

  // Status byte bit positions
  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_AUTOINC = 3;

  // CTRL register bit positions
  localparam int unsigned CTRL_AUTOINC = 0;
  localparam int unsigned CTRL_CLR_OVF = 7;

  // The readout owns the VRAM port in phases 0/1 and 4/5 while active;
  // phases 2, 3, 6, 7 and all of blanking are free for host commits.
  function automatic logic slot_free(input logic active, input logic [2:0] phase);
    return ~active | phase[1];
  endfunction

endpackage

// File: rtl/vram_write_fifo.sv
// Small synchronous FIFO buffering pending VRAM writes.
// Ports: clk/rst (async active-high), push/wdata enqueue, pop dequeues the
// head, rdata shows the head combinationally, full/empty status.
// The caller must not push when full unless it pops in the same cycle; a
// simultaneous push/pop when full overwrites the slot being released.
module vram_write_fifo #(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to distinguish full from empty
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign rdata = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Next-state for storage and pointers
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/vram_host_writer.sv
// Host-side VRAM write port. Decodes byte-wide host register writes,
// keeps an auto-incrementing VRAM pointer, queues {addr,data} writes and
// commits the queue head whenever the scan readout leaves the port free.
// Ports: clk/rst (async active-high); host bus hostCs/hostWr/hostRs/hostDin
// with status hostDout; readoutActive/readoutCount from the scan readout;
// vramWrAddr/vramWrData/vramWe toward the VRAM mux; busy = queue not empty.
module vram_host_writer
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W     = VRAM_ADDR_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hostCs,
  input  logic              hostWr,
  input  logic [1:0]        hostRs,
  input  logic [7:0]        hostDin,
  output logic [7:0]        hostDout,
  input  logic              readoutActive,
  input  logic [2:0]        readoutCount,
  output logic [ADDR_W-1:0] vramWrAddr,
  output logic [7:0]        vramWrData,
  output logic              vramWe,
  output logic              busy
);

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic               auto_inc_q, auto_inc_d;
  logic               overflow_q, overflow_d;
  logic               host_we, push_req, push, pop;
  logic               full, empty;
  logic [ENTRY_W-1:0] push_entry, head_entry;

  assign host_we    = hostCs & hostWr;
  assign push_req   = host_we && (host_rs_e'(hostRs) == RS_DATA);
  assign pop        = ~empty & slot_free(readoutActive, readoutCount);
  // A pop in the same cycle frees the slot a full queue would otherwise lack
  assign push       = push_req & (~full | pop);
  assign push_entry = {ptr_q, hostDin};

  vram_write_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head_entry),
    .full  (full),
    .empty (empty)
  );

  // Host register decode: pointer, auto-increment and sticky overflow
  always_comb begin
    ptr_d      = ptr_q;
    auto_inc_d = auto_inc_q;
    overflow_d = overflow_q;
    if (host_we) begin
      unique case (host_rs_e'(hostRs))
        RS_ADDR_LO: ptr_d[7:0] = hostDin;
        RS_ADDR_HI: ptr_d[ADDR_W-1:8] = hostDin[ADDR_W-9:0];
        RS_DATA: begin
          if (push) begin
            if (auto_inc_q) ptr_d = ptr_q + ADDR_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        RS_CTRL: begin
          auto_inc_d = hostDin[CTRL_AUTOINC];
          if (hostDin[CTRL_CLR_OVF]) overflow_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      auto_inc_q <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      auto_inc_q <= auto_inc_d;
      overflow_q <= overflow_d;
    end
  end

  // Status byte
  always_comb begin
    hostDout             = '0;
    hostDout[ST_FULL]    = full;
    hostDout[ST_EMPTY]   = empty;
    hostDout[ST_OVF]     = overflow_q;
    hostDout[ST_AUTOINC] = auto_inc_q;
  end

  assign vramWrAddr = head_entry[ENTRY_W-1:DATA_W];
  assign vramWrData = head_entry[DATA_W-1:0];
  assign vramWe     = pop;
  assign busy       = ~empty;

endmodule

// File: tb/tb_vram_host_writer.sv
// Directed bench for vram_host_writer: register decode, pointer wrap,
// slot arbitration, overflow handling and asynchronous reset.
module tb_vram_host_writer;

  localparam int unsigned AW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          hostCs, hostWr;
  logic [1:0]    hostRs;
  logic [7:0]    hostDin, hostDout;
  logic          readoutActive;
  logic [2:0]    readoutCount;
  logic [AW-1:0] vramWrAddr;
  logic [7:0]    vramWrData;
  logic          vramWe, busy;

  int checks = 0;
  int errors = 0;

  // Commit log written only by the monitor
  logic [AW-1:0] mon_addr [$];
  logic [7:0]    mon_data [$];
  logic [2:0]    mon_cnt  [$];

  always #5 clk = ~clk;

  vram_host_writer #(.ADDR_W(AW), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .hostCs        (hostCs),
    .hostWr        (hostWr),
    .hostRs        (hostRs),
    .hostDin       (hostDin),
    .hostDout      (hostDout),
    .readoutActive (readoutActive),
    .readoutCount  (readoutCount),
    .vramWrAddr    (vramWrAddr),
    .vramWrData    (vramWrData),
    .vramWe        (vramWe),
    .busy          (busy)
  );

  // Record every VRAM commit (write takes effect on this edge)
  always @(posedge clk) begin
    if (vramWe) begin
      mon_addr.push_back(vramWrAddr);
      mon_data.push_back(vramWrData);
      mon_cnt.push_back(readoutCount);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One qualified write; returns at the falling edge after the sampling edge
  task automatic host_wr(input logic [1:0] rs, input logic [7:0] din);
    @(negedge clk);
    hostCs = 1'b1; hostWr = 1'b1; hostRs = rs; hostDin = din;
    @(negedge clk);
    hostCs = 1'b0; hostWr = 1'b0;
  endtask

  task automatic set_ptr(input logic [AW-1:0] a);
    host_wr(2'd0, a[7:0]);
    host_wr(2'd1, {3'b000, a[AW-1:8]});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base;
    int exp_cnt [4];
    logic [7:0] exp_d5 [5];
    exp_cnt = '{2, 3, 6, 7};
    exp_d5  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h99};

    rst = 1'b1; hostCs = 1'b0; hostWr = 1'b0; hostRs = 2'd0; hostDin = 8'h00;
    readoutActive = 1'b0; readoutCount = 3'd0;
    idle(3);
    chk("rst_dout", 32'(hostDout), 32'h0A);
    chk("rst_we", 32'(vramWe), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    idle(2);
    chk("idle_dout", 32'(hostDout), 32'h0A);

    // Basic write during blanking
    host_wr(2'd0, 8'h34);
    host_wr(2'd1, 8'h12);
    host_wr(2'd2, 8'h41);
    chk("basic_we", 32'(vramWe), 32'h1);
    chk("basic_addr", 32'(vramWrAddr), 32'h1234);
    chk("basic_data", 32'(vramWrData), 32'h41);
    chk("basic_busy", 32'(busy), 32'h1);
    idle(1);
    chk("basic_drained_we", 32'(vramWe), 32'h0);
    chk("basic_drained_busy", 32'(busy), 32'h0);
    host_wr(2'd2, 8'h42);
    chk("basic_autoinc_addr", 32'(vramWrAddr), 32'h1235);
    idle(2);

    // Pointer wrap; ADDR_HI upper bits ignored
    host_wr(2'd0, 8'hFF);
    host_wr(2'd1, 8'hFF);
    host_wr(2'd2, 8'hE0);
    chk("wrap_addr0", 32'(vramWrAddr), 32'h1FFF);
    chk("wrap_data0", 32'(vramWrData), 32'hE0);
    host_wr(2'd2, 8'hE1);
    chk("wrap_addr1", 32'(vramWrAddr), 32'h0000);
    chk("wrap_data1", 32'(vramWrData), 32'hE1);
    idle(2);

    // Arbitration: queue four with the port owned, then sweep phases
    set_ptr(13'h0200);
    readoutActive = 1'b1; readoutCount = 3'd0;
    for (int i = 0; i < 4; i++) host_wr(2'd2, 8'(8'hA0 + i));
    chk("arb_full_dout", 32'(hostDout), 32'h09);
    chk("arb_blocked_we", 32'(vramWe), 32'h0);
    base = mon_addr.size();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      readoutCount = 3'(i);
    end
    @(negedge clk);
    chk("arb_commits", 32'(mon_addr.size() - base), 32'd4);
    if (mon_addr.size() - base == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("arb_phase", 32'(mon_cnt[base+k]), 32'(exp_cnt[k]));
        chk("arb_addr", 32'(mon_addr[base+k]), 32'(13'h0200 + k));
        chk("arb_data", 32'(mon_data[base+k]), 32'(8'hA0 + k));
      end
    end
    chk("arb_empty_dout", 32'(hostDout), 32'h0A);

    // Overflow with the port held by the readout
    readoutActive = 1'b0;
    set_ptr(13'h0300);
    readoutActive = 1'b1; readoutCount = 3'd1;
    for (int i = 0; i < 5; i++) host_wr(2'd2, 8'(8'h10 + i));
    chk("ovf_dout", 32'(hostDout), 32'h0D);
    host_wr(2'd3, 8'h81);
    chk("ovf_clr_dout", 32'(hostDout), 32'h09);
    // Push while full with a simultaneous pop is accepted without overflow
    base = mon_addr.size();
    @(negedge clk);
    readoutCount = 3'd2;
    hostCs = 1'b1; hostWr = 1'b1; hostRs = 2'd2; hostDin = 8'h99;
    @(negedge clk);
    hostCs = 1'b0; hostWr = 1'b0; readoutCount = 3'd1;
    chk("full_pushpop_dout", 32'(hostDout), 32'h09);
    readoutActive = 1'b0;
    idle(6);
    chk("ovf_commits", 32'(mon_addr.size() - base), 32'd5);
    if (mon_addr.size() - base == 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("ovf_addr", 32'(mon_addr[base+k]), 32'(13'h0300 + k));
        chk("ovf_data", 32'(mon_data[base+k]), 32'(exp_d5[k]));
      end
    end
    host_wr(2'd2, 8'h77);
    chk("ovf_ptr_after", 32'(vramWrAddr), 32'h0305);
    idle(2);

    // Auto-increment off
    host_wr(2'd3, 8'h00);
    chk("noinc_dout", 32'(hostDout), 32'h02);
    set_ptr(13'h0400);
    host_wr(2'd2, 8'h55);
    chk("noinc_addr0", 32'(vramWrAddr), 32'h0400);
    host_wr(2'd2, 8'h66);
    chk("noinc_addr1", 32'(vramWrAddr), 32'h0400);
    chk("noinc_data1", 32'(vramWrData), 32'h66);
    idle(2);

    // Reset with entries pending
    set_ptr(13'h0500);
    readoutActive = 1'b1; readoutCount = 3'd0;
    host_wr(2'd2, 8'h01);
    host_wr(2'd2, 8'h02);
    chk("prerst_busy", 32'(busy), 32'h1);
    base = mon_addr.size();
    @(negedge clk);
    readoutCount = 3'd2;
    #1;
    chk("prerst_we", 32'(vramWe), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_we", 32'(vramWe), 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_dout", 32'(hostDout), 32'h0A);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_no_commit", 32'(mon_addr.size() - base), 32'd0);
    readoutActive = 1'b0;
    host_wr(2'd2, 8'hC3);
    chk("postrst_addr0", 32'(vramWrAddr), 32'h0000);
    host_wr(2'd2, 8'hC4);
    chk("postrst_addr1", 32'(vramWrAddr), 32'h0001);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
